// File: rtl/sd_pkg.sv
// Shared definitions for the SPI-mode SD card responder:
// command indices, R1 flag bit positions, frame length and frame FSM states.
package sd_pkg;

  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD41 = 6'd41;
  localparam logic [5:0] CMD55 = 6'd55;
  localparam logic [5:0] CMD58 = 6'd58;

  localparam int unsigned R1_IDLE    = 0;
  localparam int unsigned R1_ILLEGAL = 2;
  localparam int unsigned R1_CRC_ERR = 3;

  localparam int unsigned FRAME_LEN = 48;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_RX,
    ST_DELAY,
    ST_TX
  } frame_state_t;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), MSB-first, one bit per enabled clock.
// Ports: clk, rst (async active-low), i_clr (restart from zero),
//        i_en (absorb i_bit), i_bit, o_crc (current 7-bit remainder).
module sd_crc7 (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_bit,
  output logic [6:0] o_crc
);

  logic [6:0] r_crc;
  logic [6:0] w_base;
  logic       w_fb;

  // Clear together with enable absorbs the bit into a fresh remainder,
  // so the first frame bit is never lost.
  always_comb begin
    w_base = i_clr ? '0 : r_crc;
    w_fb   = i_bit ^ w_base[6];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_crc <= '0;
    end else if (i_en) begin
      r_crc <= {w_base[5:3], w_base[2] ^ w_fb, w_base[1:0], w_fb};
    end else if (i_clr) begin
      r_crc <= '0;
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/sd_spi_responder.sv
// SPI-mode SD card emulator (card side). Oversamples sclk/cs_n/mosi in the
// clk domain, receives 48-bit command frames, answers with R1 or R7 after
// RESP_DELAY filler bytes, and tracks the idle/ACMD41 initialisation state.
// Ports: clk, rst (async active-low), sclk/cs_n/mosi (async host inputs),
//        miso, cmd_valid (1-clk pulse), cmd_index, cmd_arg, card_ready.
module sd_spi_responder
  import sd_pkg::*;
#(
  parameter int unsigned RESP_DELAY   = 1,
  parameter int unsigned ACMD41_COUNT = 3,
  parameter int unsigned CRC_CHECK    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        card_ready
);

  logic [1:0]   r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic         r_sclk_prev;
  frame_state_t r_state, w_state_nxt;
  logic [5:0]   r_bit_cnt;
  logic [2:0]   r_byte_cnt;
  logic [45:0]  r_shift;
  logic [39:0]  r_tx;
  logic         r_tx_long;
  logic         r_pending;
  logic [7:0]   r_acmd_cnt;

  logic         w_rise, w_fall, w_cs_n, w_mosi;
  logic         w_start, w_last_bit, w_good, w_delay_done, w_tx_done;
  logic         w_crc_en, w_crc_clr, w_crc_err;
  logic [6:0]   w_crc;
  logic [46:0]  w_frame;
  logic [5:0]   w_idx;
  logic [31:0]  w_arg;
  logic [7:0]   w_r1, w_cnt_sat, w_cnt_nxt;
  logic [31:0]  w_tail;
  logic         w_long, w_ready_nxt, w_pend_nxt;

  assign w_cs_n  = r_cs_sync[1];
  assign w_mosi  = r_mosi_sync[1];
  assign w_rise  = r_sclk_sync[1] & ~r_sclk_prev;
  assign w_fall  = ~r_sclk_sync[1] & r_sclk_prev;

  // Frame bits 46..0; the start bit is implied by having left HUNT.
  assign w_frame    = {r_shift, w_mosi};
  assign w_idx      = w_frame[45:40];
  assign w_arg      = w_frame[39:8];
  assign w_start    = (r_state == ST_HUNT) && w_rise && !w_cs_n && !w_mosi;
  assign w_last_bit = (r_state == ST_RX) && w_rise && (r_bit_cnt == 6'(FRAME_LEN - 1));
  assign w_good     = w_last_bit && w_frame[46] && w_frame[0];
  assign w_delay_done = (r_state == ST_DELAY) && w_fall && (r_bit_cnt == 6'd7) &&
                        (r_byte_cnt == 3'(RESP_DELAY - 1));
  // One extra falling edge after the last response bit restores miso high.
  assign w_tx_done  = (r_state == ST_TX) && w_fall &&
                      (r_byte_cnt == (r_tx_long ? 3'd5 : 3'd1));

  assign w_crc_clr  = (r_state == ST_HUNT) || w_cs_n;
  assign w_crc_en   = w_start || ((r_state == ST_RX) && w_rise && !w_cs_n && (r_bit_cnt < 6'd40));
  assign w_crc_err  = (CRC_CHECK != 0) && (w_frame[7:1] != w_crc);

  sd_crc7 u_crc7 (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_crc_clr),
    .i_en  (w_crc_en),
    .i_bit (w_mosi),
    .o_crc (w_crc)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (w_cs_n) begin
      w_state_nxt = ST_HUNT;
    end else begin
      case (r_state)
        ST_HUNT:  if (w_start)      w_state_nxt = ST_RX;
        ST_RX:    if (w_last_bit)   w_state_nxt = w_good ? ST_DELAY : ST_HUNT;
        ST_DELAY: if (w_delay_done) w_state_nxt = ST_TX;
        ST_TX:    if (w_tx_done)    w_state_nxt = ST_HUNT;
        default:                    w_state_nxt = ST_HUNT;
      endcase
    end
  end

  // Response and card-state update for the frame completing this cycle.
  always_comb begin
    w_cnt_sat   = (r_acmd_cnt >= 8'(ACMD41_COUNT)) ? r_acmd_cnt : r_acmd_cnt + 8'd1;
    w_ready_nxt = card_ready;
    w_pend_nxt  = 1'b0;
    w_cnt_nxt   = r_acmd_cnt;
    w_r1        = '0;
    w_r1[R1_IDLE] = ~card_ready;
    w_long      = 1'b0;
    w_tail      = '1;
    if (w_crc_err) begin
      w_r1[R1_CRC_ERR] = 1'b1;
    end else begin
      case (w_idx)
        CMD0: begin
          w_ready_nxt = 1'b0;
          w_cnt_nxt   = '0;
          w_r1        = 8'h01;
        end
        CMD8: begin
          w_long = 1'b1;
          w_tail = {16'h0000, 4'h0, w_arg[11:8], w_arg[7:0]};
        end
        CMD55: w_pend_nxt = 1'b1;
        CMD41: begin
          if (r_pending) begin
            w_cnt_nxt = w_cnt_sat;
            if (w_cnt_sat == 8'(ACMD41_COUNT)) w_ready_nxt = 1'b1;
            w_r1[R1_IDLE] = ~w_ready_nxt;
          end else begin
            w_r1[R1_ILLEGAL] = 1'b1;
          end
        end
        CMD58: begin
          w_long = 1'b1;
          w_tail = {card_ready ? 8'hC0 : 8'h00, 8'hFF, 8'h80, 8'h00};
        end
        default: w_r1[R1_ILLEGAL] = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '1;
      r_sclk_prev <= 1'b0;
      r_state     <= ST_HUNT;
      r_bit_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_shift     <= '0;
      r_tx        <= '1;
      r_tx_long   <= 1'b0;
      r_pending   <= 1'b0;
      r_acmd_cnt  <= '0;
      miso        <= 1'b1;
      cmd_valid   <= 1'b0;
      cmd_index   <= '0;
      cmd_arg     <= '0;
      card_ready  <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[0], sclk};
      r_cs_sync   <= {r_cs_sync[0], cs_n};
      r_mosi_sync <= {r_mosi_sync[0], mosi};
      r_sclk_prev <= r_sclk_sync[1];
      r_state     <= w_state_nxt;
      cmd_valid   <= 1'b0;
      if (w_cs_n) begin
        miso       <= 1'b1;
        r_bit_cnt  <= '0;
        r_byte_cnt <= '0;
      end else begin
        case (r_state)
          ST_HUNT: begin
            r_byte_cnt <= '0;
            if (w_start) r_bit_cnt <= 6'd1;
            else         r_bit_cnt <= '0;
          end
          ST_RX: if (w_rise) begin
            r_shift <= {r_shift[44:0], w_mosi};
            if (w_last_bit) begin
              r_bit_cnt  <= '0;
              r_byte_cnt <= '0;
              if (w_good) begin
                cmd_valid  <= 1'b1;
                cmd_index  <= w_idx;
                cmd_arg    <= w_arg;
                r_tx       <= {w_r1, w_tail};
                r_tx_long  <= w_long;
                r_pending  <= w_pend_nxt;
                if (!w_crc_err) begin
                  card_ready <= w_ready_nxt;
                  r_acmd_cnt <= w_cnt_nxt;
                end
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 6'd1;
            end
          end
          ST_DELAY: if (w_fall) begin
            miso <= 1'b1;
            if (r_bit_cnt == 6'd7) begin
              r_bit_cnt  <= '0;
              r_byte_cnt <= w_delay_done ? 3'd0 : r_byte_cnt + 3'd1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 6'd1;
            end
          end
          ST_TX: if (w_fall) begin
            if (w_tx_done) begin
              miso       <= 1'b1;
              r_bit_cnt  <= '0;
              r_byte_cnt <= '0;
            end else begin
              miso <= r_tx[39];
              r_tx <= {r_tx[38:0], 1'b1};
              if (r_bit_cnt == 6'd7) begin
                r_bit_cnt  <= '0;
                r_byte_cnt <= r_byte_cnt + 3'd1;
              end else begin
                r_bit_cnt <= r_bit_cnt + 6'd1;
              end
            end
          end
          default: r_bit_cnt <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Self-checking bench: two responders (CRC checked / unchecked, different
// response delays) share sclk/mosi with separate chip selects.
module tb_sd_spi_responder;

  localparam int ACNT = 3;

  logic clk = 1'b0;
  logic rst_n, sclk, mosi, cs0, cs1;
  logic miso0, miso1, vld0, vld1, rdy0, rdy1;
  logic [5:0]  idx0, idx1;
  logic [31:0] arg0, arg1;

  int checks = 0, errors = 0;
  int vcnt0 = 0, vcnt1 = 0;

  bit m_ready[2];
  bit m_pend[2];
  int m_cnt[2];
  int m_crc_chk[2] = '{1, 0};
  int m_delay[2]   = '{1, 2};
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (vld0) vcnt0++;
    if (vld1) vcnt1++;
  end

  sd_spi_responder #(.RESP_DELAY(1), .ACMD41_COUNT(ACNT), .CRC_CHECK(1)) dut0 (
    .clk(clk), .rst(rst_n), .sclk(sclk), .cs_n(cs0), .mosi(mosi), .miso(miso0),
    .cmd_valid(vld0), .cmd_index(idx0), .cmd_arg(arg0), .card_ready(rdy0));

  sd_spi_responder #(.RESP_DELAY(2), .ACMD41_COUNT(ACNT), .CRC_CHECK(0)) dut1 (
    .clk(clk), .rst(rst_n), .sclk(sclk), .cs_n(cs1), .mosi(mosi), .miso(miso1),
    .cmd_valid(vld1), .cmd_index(idx1), .cmd_arg(arg1), .card_ready(rdy1));

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  function automatic logic [47:0] mkframe(input logic [5:0] i, input logic [31:0] a, input bit bad_crc);
    logic [39:0] h;
    logic [6:0]  c;
    h = {2'b01, i, a};
    c = crc7(h) ^ (bad_crc ? 7'h01 : 7'h00);
    return {h, c, 1'b1};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ready[i] = 0;
      m_pend[i]  = 0;
      m_cnt[i]   = 0;
    end
  endtask

  // Card behaviour from the command rules; fills exp_q with every byte the
  // host should read back (fillers, response, trailing idle bytes).
  task automatic model_cmd(input int id, input logic [47:0] f, output bit v);
    logic [5:0]  i;
    logic [31:0] a;
    logic [7:0]  idle;
    bit          crc_ok;
    i = f[45:40];
    a = f[39:8];
    exp_q.delete();
    v = f[46] && f[0];
    for (int n = 0; n < m_delay[id]; n++) exp_q.push_back(8'hFF);
    if (v) begin
      crc_ok = (m_crc_chk[id] == 0) || (f[7:1] == crc7(f[47:8]));
      idle   = m_ready[id] ? 8'h00 : 8'h01;
      if (!crc_ok) begin
        m_pend[id] = 0;
        exp_q.push_back(idle | 8'h08);
      end else begin
        case (i)
          6'd0: begin
            m_ready[id] = 0; m_cnt[id] = 0; m_pend[id] = 0;
            exp_q.push_back(8'h01);
          end
          6'd8: begin
            m_pend[id] = 0;
            exp_q.push_back(idle); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
            exp_q.push_back({4'h0, a[11:8]}); exp_q.push_back(a[7:0]);
          end
          6'd55: begin
            m_pend[id] = 1;
            exp_q.push_back(idle);
          end
          6'd41: begin
            if (m_pend[id]) begin
              if (m_cnt[id] < ACNT) m_cnt[id]++;
              if (m_cnt[id] == ACNT) m_ready[id] = 1;
              exp_q.push_back(m_ready[id] ? 8'h00 : 8'h01);
            end else begin
              exp_q.push_back(idle | 8'h04);
            end
            m_pend[id] = 0;
          end
          6'd58: begin
            m_pend[id] = 0;
            exp_q.push_back(idle); exp_q.push_back(m_ready[id] ? 8'hC0 : 8'h00);
            exp_q.push_back(8'hFF); exp_q.push_back(8'h80); exp_q.push_back(8'h00);
          end
          default: begin
            m_pend[id] = 0;
            exp_q.push_back(idle | 8'h04);
          end
        endcase
      end
    end
    while (exp_q.size() < m_delay[id] + 6) exp_q.push_back(8'hFF);
  endtask

  task automatic set_cs(input int id, input logic val);
    if (id == 0) cs0 = val;
    else         cs1 = val;
  endtask

  // One SPI mode-0 bit: MISO read just before the rising edge.
  task automatic xbit(input logic b, input int id, output logic r);
    mosi = b;
    #40;
    r = (id == 0) ? miso0 : miso1;
    sclk = 1'b1;
    #40;
    sclk = 1'b0;
  endtask

  task automatic xbyte(input logic [7:0] b, input int id, output logic [7:0] r);
    logic rb;
    for (int i = 7; i >= 0; i--) begin
      xbit(b[i], id, rb);
      r[i] = rb;
    end
  endtask

  task automatic run_cmd(input int id, input logic [47:0] f, input string tag);
    bit v;
    int v0, v1;
    logic [7:0] r;
    model_cmd(id, f, v);
    v0 = (id == 0) ? vcnt0 : vcnt1;
    set_cs(id, 1'b0);
    #40;
    for (int k = 0; k < 6; k++) xbyte(f[47-8*k -: 8], id, r);
    for (int k = 0; k < exp_q.size(); k++) begin
      xbyte(8'hFF, id, r);
      chk($sformatf("%s byte%0d", tag, k), r, exp_q[k]);
    end
    set_cs(id, 1'b1);
    mosi = 1'b1;
    #40;
    v1 = (id == 0) ? vcnt0 : vcnt1;
    chk({tag, " cmd_valid count"}, v1 - v0, v ? 1 : 0);
    if (v) begin
      chk({tag, " cmd_index"}, (id == 0) ? idx0 : idx1, f[45:40]);
      chk({tag, " cmd_arg"},   (id == 0) ? arg0 : arg1, f[39:8]);
    end
    chk({tag, " card_ready"}, (id == 0) ? rdy0 : rdy1, m_ready[id]);
    chk({tag, " miso idle"},  (id == 0) ? miso0 : miso1, 1'b1);
  endtask

  initial begin
    logic [47:0] f;
    logic [7:0]  r;
    logic        rb;
    bit          all_high;
    int          v0, pick, id;
    logic [5:0]  ri;

    rst_n = 1'b0; sclk = 1'b0; mosi = 1'b1; cs0 = 1'b1; cs1 = 1'b1;
    #32;
    chk("reset miso0", miso0, 1'b1);
    chk("reset cmd_valid0", vld0, 1'b0);
    chk("reset cmd_index0", idx0, 6'd0);
    chk("reset cmd_arg0", arg0, 32'd0);
    chk("reset card_ready0", rdy0, 1'b0);
    chk("reset miso1", miso1, 1'b1);
    chk("reset card_ready1", rdy1, 1'b0);
    rst_n = 1'b1;
    #30;
    model_reset();

    run_cmd(0, 48'h40_00_00_00_00_95, "cmd0");
    run_cmd(1, 48'h40_00_00_00_00_95, "cmd0 nc");
    run_cmd(0, 48'h48_00_00_01_AA_87, "cmd8");
    run_cmd(0, 48'h40_00_00_00_00_94, "cmd0 badcrc");
    run_cmd(1, 48'h40_00_00_00_00_94, "cmd0 badcrc nc");
    for (int n = 0; n < 3; n++) begin
      run_cmd(0, 48'h77_00_00_00_00_65, $sformatf("cmd55 #%0d", n));
      run_cmd(0, 48'h69_40_00_00_00_77, $sformatf("acmd41 #%0d", n));
    end
    run_cmd(0, mkframe(6'd58, 32'h0, 0), "cmd58 ready");

    // Reset while R7 byte 3 of CMD8 is on the wire.
    cs0 = 1'b0;
    #40;
    f = 48'h48_00_00_01_AA_87;
    for (int k = 0; k < 6; k++) xbyte(f[47-8*k -: 8], 0, r);
    for (int k = 0; k < 4; k++) xbyte(8'hFF, 0, r);
    xbit(1'b1, 0, rb);
    xbit(1'b1, 0, rb);
    #40;
    chk("pre-reset miso0 low", miso0, 1'b0);
    rst_n = 1'b0;
    #10;
    chk("mid-reset miso0", miso0, 1'b1);
    chk("mid-reset card_ready0", rdy0, 1'b0);
    model_reset();
    cs0 = 1'b1;
    #20;
    rst_n = 1'b1;
    #40;
    run_cmd(0, 48'h40_00_00_00_00_95, "cmd0 after reset");

    // Chip select dropped after 20 bits of CMD0.
    v0 = vcnt0;
    all_high = 1;
    cs0 = 1'b0;
    #40;
    f = 48'h40_00_00_00_00_95;
    for (int b = 0; b < 20; b++) begin
      xbit(f[47-b], 0, rb);
      if (rb !== 1'b1) all_high = 0;
    end
    cs0 = 1'b1;
    mosi = 1'b1;
    #80;
    chk("abort cmd_valid count", vcnt0 - v0, 0);
    chk("abort miso stayed high", all_high, 1'b1);
    chk("abort miso idle", miso0, 1'b1);
    run_cmd(0, 48'h40_00_00_00_00_95, "cmd0 after abort");

    run_cmd(1, 48'h51_00_00_00_00_55, "cmd17 idle");
    for (int n = 0; n < 3; n++) begin
      run_cmd(1, mkframe(6'd55, 32'h0, 0), $sformatf("nc cmd55 #%0d", n));
      run_cmd(1, mkframe(6'd41, 32'h4000_0000, 0), $sformatf("nc acmd41 #%0d", n));
    end
    run_cmd(1, 48'h51_00_00_00_00_55, "cmd17 ready");

    for (int n = 0; n < 20; n++) begin
      id   = int'($urandom_range(0, 1));
      pick = int'($urandom_range(0, 6));
      case (pick)
        0: ri = 6'd0;
        1: ri = 6'd8;
        2: ri = 6'd41;
        3: ri = 6'd55;
        4: ri = 6'd58;
        5: ri = 6'd17;
        default: ri = 6'($urandom_range(0, 63));
      endcase
      f = mkframe(ri, $urandom, ($urandom_range(0, 5) == 0));
      case ($urandom_range(0, 9))
        0: f[46] = 1'b0;
        1: f[0]  = 1'b0;
        default: ;
      endcase
      run_cmd(id, f, $sformatf("rand%0d id%0d cmd%0d", n, id, ri));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_spi_responder.md
Name: sd_spi_responder

Overview:
- SPI-mode SD card emulator: the card end of the link driven by the SD host controller.
- Receives 48-bit command frames on MOSI and returns R1 and R7 responses on MISO.
- Used as a bench and loopback target for the host, and as a card stand-in when no physical card is fitted.
- Runs entirely in the system clock domain, oversampling SCLK, CS_n and MOSI.

Parameters:
- RESP_DELAY, 1: number of 0xFF filler bytes (N_CR) between the command end bit and the first response byte; legal range 1..8.
- ACMD41_COUNT, 3: number of ACMD41 commands answered 0x01 before the card leaves idle; the ACMD41_COUNT-th answers 0x00.
- CRC_CHECK, 1: 1 = verify CRC7 on every command; 0 = ignore the CRC field.

Ports:
- clk  in  1  system clock; must run at least 8x SCLK.
- rst  in  1  asynchronous, active-low reset.
- sclk  in  1  SPI clock from host, asynchronous to clk.
- cs_n  in  1  chip select, active low, asynchronous.
- mosi  in  1  host-to-card data, asynchronous.
- miso  out  1  card-to-host data.
- cmd_valid  out  1  one-clk pulse when a well-framed command is received.
- cmd_index  out  6  index of the last received command.
- cmd_arg  out  32  argument of the last received command.
- card_ready  out  1  card has left idle state.

Behaviour:
- Reset values: miso=1, cmd_valid=0, cmd_index=0, cmd_arg=0, card_ready=0. Card state = IDLE, acmd_pending=0, acmd41 counter=0. Reset mid-frame or mid-response aborts immediately.
- Input sync: 2-FF synchronizers on sclk, cs_n and mosi; edges are detected on the synchronized sclk.
- Timing: SPI mode 0. MOSI is sampled on the sclk rising edge. MISO updates within 3 clk of the sclk falling edge. Bit order is MSB first.
- Frame FSM states: HUNT, RX, DELAY, TX.
- HUNT: wait for mosi=0 sampled with cs_n=0 (the start bit).
- RX: shift 48 bits total, counting the start bit. Bit 46 must be 1 (transmission bit). Bit 0 must be 1 (end bit). If either is wrong, discard the frame, go to HUNT, send no response and raise no cmd_valid.
- On a good frame: latch cmd_index and cmd_arg, pulse cmd_valid, compute the response, go to DELAY.
- DELAY: send RESP_DELAY bytes of 0xFF, then go to TX.
- TX: send 1 byte (R1) or 5 bytes (R7), then drive miso=1 and return to HUNT. Start bits on MOSI during DELAY/TX are ignored; no pipelined commands.
- cs_n=1 at any point: return to HUNT, miso=1, bit/byte counters cleared. Card state is retained.
- R1 bit0 (idle) = ~card_ready. R1 bit2 = illegal command. R1 bit3 = CRC error. All other R1 bits are 0.
- CRC error (CRC_CHECK=1 and CRC7 over the first 40 bits ≠ bits 7:1): R1 = idle bit | 0x08, no state change, acmd_pending cleared.
- CMD0: card_ready=0, acmd41 counter=0, R1 = 0x01.
- CMD8: R7 = R1, 0x00, 0x00, {4'h0, arg[11:8]}, arg[7:0].
- CMD55: R1, sets acmd_pending.
- CMD41 with acmd_pending set: increment the counter. When the counter reaches ACMD41_COUNT, set card_ready and reply 0x00; otherwise reply 0x01. Counter saturates.
- CMD41 without acmd_pending: illegal command.
- CMD58: R7-style reply = R1, 0xC0 if card_ready else 0x00, 0xFF, 0x80, 0x00.
- Any other index: R1 = idle bit | 0x04.
- acmd_pending is cleared by any command other than CMD55.
- Bit counter is 6 bits wide and never wraps past 47. Byte counter is 3 bits wide.

Decomposition:
- Shared package sd_pkg:
  - command index constants: CMD0=0, CMD8=8, CMD41=41, CMD55=55, CMD58=58
  - R1 bit positions: IDLE=0, ILLEGAL=2, CRC_ERR=3
  - frame length 48
  - frame FSM state enum
- Sub-module sd_crc7: serial CRC7 (polynomial x^7+x^3+1), with clear, enable and bit input and a 7-bit output. It is fed each RX bit as that bit is sampled.

Test Plan:
- CMD0 frame 40 00 00 00 00 95 -> cmd_valid pulses with index 0; MISO returns FF, then 01.
- CMD8 frame 48 00 00 01 AA 87 -> MISO returns FF, 01, 00, 00, 01, AA.
- After CMD0, send CMD55 (77 00 00 00 00 65) then ACMD41 (69 40 00 00 00 77), repeated 3 times. Each CMD55 replies 01. The ACMD41 replies are 01, 01, 00; card_ready rises after the third. A following CMD58 returns 00, C0, FF, 80, 00.
- CMD0 with CRC byte 94 and CRC_CHECK=1 -> R1 = 09 and card state unchanged. The same frame with CRC_CHECK=0 -> R1 = 01.
- cs_n raised after 20 bits of CMD0 -> no cmd_valid and miso stays 1. The next full CMD0 -> R1 = 01.
- rst asserted during R7 byte 3 of CMD8 -> miso=1 within 1 clk and card_ready=0. A subsequent CMD0 is answered normally.
- CMD17 (51 00 00 00 00 55) with CRC_CHECK=0 -> R1 = 05. With the card ready, the same frame -> R1 = 04.
